// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } fetch_state_e;

  localparam int unsigned InstW          = 32;
  localparam logic [31:0] PcInc          = 32'd4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // One buffered instruction: its PC tag and the fetched word.
  typedef struct packed {
    logic [InstW-1:0] pc;
    logic [InstW-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Depth-entry synchronous FIFO of {pc, word} entries with a clear that wins over push/pop.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  fetch_entry_t    wdata_i,
  input  logic            pop_i,
  output fetch_entry_t    rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; reset to zero so the head reads as 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues in-order word requests under a credit limit,
// buffers returned words with their PCs and squashes stale fetches on redirect.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter logic [31:0] ResetPc = DefaultResetPc
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i
);

  localparam int unsigned CntW     = $clog2(Depth) + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(Depth);

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] squash_q, squash_d;
  logic [CntW-1:0] occupancy;
  logic [CntW:0]   credit_used;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clear;
  fetch_entry_t    fifo_wdata, fifo_rdata;
  logic            req_fire, resp_ok;
  logic [31:0]     target_aligned;

  // In-flight requests plus buffered words may never exceed the FIFO size, so a push
  // can never find the FIFO full.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, occupancy};
  assign imem_req_valid_o = (state_q != StIdle) && (credit_used < DepthExt) && !fifo_full;
  assign imem_addr_o      = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  // Responses with nothing outstanding, or before IDLE exits, are protocol noise.
  assign resp_ok          = imem_resp_valid_i && (outstanding_q != '0) && (state_q != StIdle);
  assign target_aligned   = {redirect_target_i[31:2], 2'b00};

  assign inst_valid_o = !fifo_empty;
  assign inst_data_o  = fifo_rdata.data;
  assign inst_pc_o    = fifo_rdata.pc;
  assign fifo_pop     = inst_valid_o && inst_ready_i;
  assign fifo_wdata   = '{pc: resp_pc_q, data: imem_resp_data_i};

  fetch_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(fifo_clear),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(occupancy)
  );

  // Next-state: redirect wins; otherwise receive/discard responses and step the FSM.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    squash_d      = squash_q;
    fifo_push     = 1'b0;
    fifo_clear    = 1'b0;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_ok);

    if (req_fire) fetch_pc_d = fetch_pc_q + PcInc;

    if (redirect_valid_i) begin
      // Everything still in flight after this edge (including a request accepted now)
      // belongs to the wrong path; a response arriving now is simply dropped.
      fifo_clear = 1'b1;
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      squash_d   = outstanding_d;
      state_d    = (outstanding_d != '0) ? StFlush : StRun;
    end else begin
      if (resp_ok) begin
        if (squash_q != '0) begin
          squash_d = squash_q - CntW'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + PcInc;
        end
      end
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StRun;
        StFlush: if (squash_d == '0) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      fetch_pc_q    <= ResetPc;
      resp_pc_q     <= ResetPc;
      outstanding_q <= '0;
      squash_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
    end
  end

endmodule
